// File: rtl/opd_pkg.sv
// Shared types and constants for the OPD signal chain (ADC reader and filter).
package opd_pkg;

  // Width of one ADC conversion word; the input filter is built for this width.
  localparam int OPD_DATA_WIDTH = 24;

  // ADC reader frame sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } adc_state_t;

  // One signed sample as exchanged between reader and filter.
  typedef logic signed [OPD_DATA_WIDTH-1:0] sample_t;

  // Cycle index (relative to the frame start cycle) in which the tick pulses.
  function automatic int frame_tick_cycle(input int conv_cycles,
                                          input int clk_div,
                                          input int data_width);
    return conv_cycles + 2 * clk_div * data_width + 1;
  endfunction

endpackage

// File: rtl/opd_sclk_gen.sv
// Serial clock divider: while enabled, produces sclk (low CLK_DIV cycles,
// then high CLK_DIV cycles per bit) plus single-cycle strobes marking the
// edge that raises sclk and the edge that ends a bit.
module opd_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic bit_done_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;
  logic          wrap;

  assign wrap = (div_q == DIV_LAST);

  // Next-state: count within a half-period, flip phase at each wrap; park at
  // phase 0 / count 0 whenever disabled so every burst starts with a low half.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (!en_i) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  // sclk is the phase register itself, so it is glitch-free and registered.
  assign sclk_o     = phase_q;
  // Strobes qualify the edge that ends the low half (sclk rises) and the
  // edge that ends the high half (bit complete).
  assign rise_o     = en_i & ~phase_q & wrap;
  assign bit_done_o = en_i &  phase_q & wrap;

endmodule

// File: rtl/opd_adc_reader.sv
// OPD front end: sequences convert / chip-select / serial-clock to a 24-bit
// serial ADC, shifts the word in MSB-first and presents it with a tick.
module opd_adc_reader
  import opd_pkg::*;
#(
  parameter int DATA_WIDTH    = OPD_DATA_WIDTH,
  parameter int CLK_DIV       = 4,
  parameter int CONV_CYCLES   = 50,
  parameter int SAMPLE_PERIOD = 400
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  sdo_i,
  output logic                  cnv_o,
  output logic                  cs_n_o,
  output logic                  sclk_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  tick_o
);

  // Parameter sanity: the frame must fit inside one sample period.
  if (DATA_WIDTH != OPD_DATA_WIDTH) begin : g_bad_width
    $error("opd_adc_reader: DATA_WIDTH must equal OPD_DATA_WIDTH");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("opd_adc_reader: CLK_DIV must be at least 1");
  end
  if (CONV_CYCLES < 1) begin : g_bad_conv
    $error("opd_adc_reader: CONV_CYCLES must be at least 1");
  end
  if (SAMPLE_PERIOD <= frame_tick_cycle(CONV_CYCLES, CLK_DIV, DATA_WIDTH) + 1) begin : g_bad_period
    $error("opd_adc_reader: SAMPLE_PERIOD too short for one frame");
  end

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [PW-1:0] PCNT_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  adc_state_t              state_q;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [CW-1:0]           conv_q;
  logic [BW-1:0]           bit_q;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    cnv_q, cs_n_q, tick_q;
  logic                    sclk_en, sclk_rise, bit_done;

  // Serial clock only runs while the word is being shifted out of the ADC.
  assign sclk_en = (state_q == SHIFT);

  opd_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (sclk_en),
    .sclk_o     (sclk_o),
    .rise_o     (sclk_rise),
    .bit_done_o (bit_done)
  );

  // Free-running period counter; frames may only start where it reads zero.
  assign pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;

  // Period counter register, independent of enable.
  always_ff @(posedge clk_i) begin
    if (reset_i) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

  // Shift in one ADC bit on each edge that raises sclk, MSB arriving first.
  assign sr_d = sclk_rise ? {sr_q[DATA_WIDTH-2:0], sdo_i} : sr_q;

  // Shift register; cleared on reset so an aborted frame leaves nothing behind.
  always_ff @(posedge clk_i) begin
    if (reset_i) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  // Frame sequencer with registered strobes; outputs change on the same edge
  // as the state so each phase lines up exactly with its state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnv_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      tick_q  <= 1'b0;
      data_q  <= '0;
      conv_q  <= '0;
      bit_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pcnt_q == '0 && enable_i) begin
            state_q <= CONVERT;
            cnv_q   <= 1'b1;
            conv_q  <= '0;
          end
        end
        CONVERT: begin
          if (conv_q == CONV_LAST) begin
            state_q <= SHIFT;
            cnv_q   <= 1'b0;
            cs_n_q  <= 1'b0;
            bit_q   <= '0;
          end else begin
            conv_q <= conv_q + 1'b1;
          end
        end
        SHIFT: begin
          if (bit_done) begin
            if (bit_q == BIT_LAST) begin
              // Last bit was captured on its rising edge; publish the word.
              state_q <= DONE;
              cs_n_q  <= 1'b1;
              tick_q  <= 1'b1;
              data_q  <= sr_q;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cnv_o  = cnv_q;
  assign cs_n_o = cs_n_q;
  assign tick_o = tick_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_opd_adc_reader.sv
// Self-checking bench for opd_adc_reader: an ADC serialiser drives sdo_i and
// a frame-timeline reference model predicts every output on every cycle.
module tb_opd_adc_reader;

  localparam int W      = 24;
  localparam int DIV    = 4;
  localparam int CONV   = 50;
  localparam int PER    = 400;
  localparam int T_CS0  = CONV + 1;
  localparam int T_CS1  = CONV + 2 * DIV * W;
  localparam int T_TICK = T_CS1 + 1;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         enable_i = 1'b0;
  logic         sdo_i = 1'b0;
  logic         cnv_o, cs_n_o, sclk_o, tick_o;
  logic [W-1:0] data_o;

  always #5 clk = ~clk;

  opd_adc_reader #(
    .DATA_WIDTH    (W),
    .CLK_DIV       (DIV),
    .CONV_CYCLES   (CONV),
    .SAMPLE_PERIOD (PER)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .sdo_i    (sdo_i),
    .cnv_o    (cnv_o),
    .cs_n_o   (cs_n_o),
    .sclk_o   (sclk_o),
    .data_o   (data_o),
    .tick_o   (tick_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: where we are in the frame timeline.
  int           pcnt_m = 0;
  bit           act_m  = 1'b0;
  int           t_m    = 0;
  logic [W-1:0] word_m = '0;
  logic [W-1:0] data_m = '0;
  logic [W-1:0] wq[$];

  // ADC serialiser / monitor state.
  logic prev_cs   = 1'b1;
  logic prev_sclk = 1'b0;
  int   bit_idx   = 0;
  int   rises     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the model across one rising edge using the inputs held at it.
  task automatic model_edge();
    bit start;
    if (reset_i) begin
      pcnt_m = 0;
      act_m  = 1'b0;
      t_m    = 0;
      data_m = '0;
    end else begin
      start = !act_m && (pcnt_m == 0) && enable_i;
      if (act_m) begin
        t_m++;
        if (t_m > T_TICK) act_m = 1'b0;
        else if (t_m == T_TICK) data_m = word_m;
      end
      if (start) begin
        act_m  = 1'b1;
        t_m    = 1;
        word_m = (wq.size() > 0) ? wq.pop_front() : W'($urandom);
      end
      pcnt_m = (pcnt_m + 1) % PER;
    end
  endtask

  // Compare every output against the timeline for the current cycle.
  task automatic check_all();
    bit in_shift;
    in_shift = act_m && (t_m >= T_CS0) && (t_m <= T_CS1);
    chk("cnv",  32'(cnv_o),  32'(act_m && t_m >= 1 && t_m <= CONV));
    chk("cs_n", 32'(cs_n_o), 32'(!in_shift));
    chk("sclk", 32'(sclk_o), 32'(in_shift && ((t_m - T_CS0) % (2 * DIV)) >= DIV));
    chk("tick", 32'(tick_o), 32'(act_m && t_m == T_TICK));
    chk("data", 32'(data_o), 32'(data_m));
    if (prev_cs && !cs_n_o) rises = 0;
    if (!cs_n_o && sclk_o && !prev_sclk) rises++;
    if (tick_o) begin
      chk("sclk_rises", 32'(rises), 32'(W));
      chk("tick_cycle", 32'(t_m), 32'(T_TICK));
    end
  endtask

  // ADC behaviour: MSB on chip-select fall, next bit after each sclk fall,
  // junk on the line while deselected.
  task automatic adc_drive();
    if (prev_cs && !cs_n_o) bit_idx = 0;
    else if (!cs_n_o && prev_sclk && !sclk_o) bit_idx++;
    if (!cs_n_o) sdo_i = (bit_idx < W) ? word_m[W-1-bit_idx] : 1'b0;
    else         sdo_i = 1'($urandom);
    prev_cs   = cs_n_o;
    prev_sclk = sclk_o;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    adc_drive();
    cyc++;
  endtask

  task automatic wait_t(input int k);
    int n = 0;
    while (!(act_m && t_m == k) && n < 2 * PER) begin
      step();
      n++;
    end
    if (n >= 2 * PER) chk("wait_frame_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_pcnt(input int k);
    int n = 0;
    while (pcnt_m != k && n < 2 * PER) begin
      step();
      n++;
    end
    if (n >= 2 * PER) chk("wait_pcnt_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    // Reset held for 5 cycles, outputs checked each cycle.
    reset_i  = 1'b1;
    enable_i = 1'b0;
    repeat (5) step();

    // Directed words first, then random ones.
    wq.push_back(24'hA5C3F1);
    wq.push_back(24'h800000);
    wq.push_back(24'h7FFFFF);
    wq.push_back(24'hFFFFFF);
    reset_i  = 1'b0;
    enable_i = 1'b1;
    repeat (4 * PER + 10) step();

    // Enable dropped mid-frame: frame completes, nothing afterwards.
    wait_t(100);
    enable_i = 1'b0;
    repeat (2 * PER) step();

    // Reset during the shift phase, then recovery.
    enable_i = 1'b1;
    wait_t(150);
    reset_i = 1'b1;
    repeat (3) step();
    reset_i = 1'b0;
    repeat (2 * PER) step();

    // Late enable: must wait for the period counter to wrap.
    enable_i = 1'b0;
    repeat (PER) step();
    wait_pcnt(10);
    enable_i = 1'b1;
    repeat (2 * PER) step();

    // Random enable toggling.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(50, 500)) step();
      enable_i = 1'($urandom);
    end
    enable_i = 1'b1;
    repeat (PER + 10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opd_adc_reader.md
# opd_adc_reader

Front-end stage of the OPD signal chain. It drives a 24-bit SAR/serial ADC over a SPI-style read-only link (convert strobe, chip select, serial clock, serial data), assembles each conversion MSB-first into a two's-complement word, and presents it with a one-cycle `tick_o`. Its `data_o`/`tick_o` pair feeds the OPD input filter's `data_i`/`tick_i` directly.

## Interface
Parameters:
- `DATA_WIDTH`, default 24: bits per conversion; fixed to match the filter input.
- `CLK_DIV`, default 4: `clk_i` cycles per `sclk_o` half-period; must be at least 1.
- `CONV_CYCLES`, default 50: number of `clk_i` cycles that `cnv_o` is held high (ADC conversion time).
- `SAMPLE_PERIOD`, default 400: `clk_i` cycles between conversion starts; must exceed `CONV_CYCLES + 2*CLK_DIV*DATA_WIDTH + 2`. Violations fail elaboration via an assertion.

Ports:
- `clk_i`  in  1  system clock; all logic is in this single clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  allows new frames to start.
- `sdo_i`  in  1  ADC serial data; the ADC places its MSB on `cs_n_o` fall and updates on `sclk_o` falling edges.
- `cnv_o`  out  1  conversion strobe.
- `cs_n_o`  out  1  ADC chip select, active low.
- `sclk_o`  out  1  serial clock; idles low.
- `data_o`  out  DATA_WIDTH  last complete sample, two's complement.
- `tick_o`  out  1  one-cycle pulse; `data_o` is new in this cycle.

## Operation
- Period counter `pcnt` counts 0..SAMPLE_PERIOD-1 and wraps. It runs whenever the block is out of reset, regardless of `enable_i`.
- FSM states: IDLE → CONVERT → SHIFT → DONE → IDLE.
- IDLE: when `pcnt==0` and `enable_i==1`, go to CONVERT. If `enable_i` rises mid-period, the frame waits for the next `pcnt==0`.
- CONVERT: `cnv_o=1` for exactly CONV_CYCLES cycles, then go to SHIFT.
- SHIFT:
  - `cs_n_o=0`. Each bit occupies 2*CLK_DIV cycles: `sclk_o` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `sdo_i` is shifted into the LSB of the shift register on the clock edge that drives `sclk_o` high.
  - A bit counter runs 0..DATA_WIDTH-1. After the last high phase, go to DONE.
- DONE: for one cycle, `data_o` is loaded from the shift register, `tick_o=1`, `cs_n_o=1`, `sclk_o=0`. Then go to IDLE.
- Deasserting `enable_i` mid-frame has no effect: the frame completes and ticks. No further frames start.
- No arithmetic is applied to the sample; bits pass through unchanged (0x800000 is negative full scale).

## Timing
- Reset values: `cnv_o=0`, `cs_n_o=1`, `sclk_o=0`, `tick_o=0`, `data_o=0`, FSM=IDLE, `pcnt=0`, shift register=0.
- Frame timeline, with cycle 0 the cycle where `pcnt==0` and `enable_i=1` in IDLE:
  - `cnv_o` is high in cycles 1..CONV_CYCLES.
  - `cs_n_o` is low in cycles CONV_CYCLES+1 .. CONV_CYCLES+2*CLK_DIV*DATA_WIDTH.
  - `tick_o` pulses in cycle CONV_CYCLES+2*CLK_DIV*DATA_WIDTH+1. With the defaults this is cycle 243.
- `tick_o` is never high on two consecutive cycles. Between ticks, `data_o` is stable.
- In steady state, ticks are exactly SAMPLE_PERIOD cycles apart.
- Reset asserted mid-frame: on the next edge all outputs return to their reset values, the partial word is discarded, and no tick is issued. After release, the first frame starts at `pcnt==0`, i.e. in the first cycle after release if `enable_i=1`.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Structure
- Shared package `opd_pkg`: `OPD_DATA_WIDTH=24`, FSM state enum `adc_state_t` (IDLE, CONVERT, SHIFT, DONE), and a `sample_t` typedef (`logic signed [23:0]`), also used by the filter.
- One natural sub-module, `opd_sclk_gen`: a CLK_DIV divider with enable. It produces `sclk_o`, a rising-edge sample strobe and a bit-done strobe. The FSM, counters and shift register stay in the top module.

## Test plan
- Reset values: hold `reset_i` for 5 cycles → all outputs at their reset values; then release with `enable_i=1` → `cnv_o` rises 1 cycle after release.
- Single frame: ADC model serialises 0xA5C3F1 → `tick_o` in cycle 243, `data_o=0xA5C3F1`; exactly 24 `sclk_o` rising edges while `cs_n_o=0`.
- Periodic run: model returns 0x800000, 0x7FFFFF, 0xFFFFFF on successive frames → ticks 400 cycles apart with those values in order.
- Enable dropped: `enable_i` falls at cycle 100 of a frame → that frame still ticks at cycle 243; no `cnv_o` or `tick_o` afterwards.
- Reset mid-shift: `reset_i` asserted at cycle 150 → no tick, `data_o=0`, `cs_n_o=1` the next cycle; after release the next frame returns a correct word.
- Late enable: `enable_i` rises at `pcnt=10` → `cnv_o` stays low until `pcnt` wraps to 0.
